// File: rtl/nibble_deserializer_if.sv
// Serial-in / word-out bundle between a bit source and the deserializer.
// The master side drives the serial line; the slave side returns the word.
interface nibble_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] D;
    logic             en;
    logic             busy;
    logic             err;
    logic [7:0]       good_cnt;

    modport master (
        output sin, sin_valid,
        input  D, en, busy, err, good_cnt
    );

    modport slave (
        input  sin, sin_valid,
        output D, en, busy, err, good_cnt
    );
endinterface

// File: rtl/nibble_deserializer.sv
// Framed serial-to-parallel converter feeding a WIDTH-bit enabled register.
// Bad or timed-out frames raise err and never strobe en.
module nibble_deserializer #(
    parameter int WIDTH      = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit ODD_PARITY = 1'b0,
    parameter int TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_deserializer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [TW-1:0] GAP_MAX  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             perr_q, perr_d;
    logic [TW-1:0]    gap_q, gap_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             en_q, en_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [7:0]       good_q, good_d;
    logic             par_exp;
    logic             time_out;

    assign par_exp  = (^shift_q) ^ ODD_PARITY;
    // Fires on the TIMEOUT-th consecutive idle cycle of an open frame.
    assign time_out = (TIMEOUT > 0) && (state_q != IDLE)
                      && !bus.sin_valid && (gap_q == GAP_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        gap_d   = gap_q;
        d_d     = d_q;
        en_d    = 1'b0;
        err_d   = err_q;
        good_d  = good_q;

        if (state_q == IDLE || bus.sin_valid || TIMEOUT == 0) begin
            gap_d = '0;
        end else begin
            gap_d = gap_q + TW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (bus.sin_valid && !bus.sin) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    perr_d  = 1'b0;
                end
            end
            DATA: begin
                if (bus.sin_valid) begin
                    shift_d[cnt_q] = bus.sin;
                    if (cnt_q == LAST_BIT) begin
                        state_d = PARITY_EN ? PAR : STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PAR: begin
                if (bus.sin_valid) begin
                    perr_d  = (bus.sin != par_exp);
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bus.sin_valid) begin
                    state_d = IDLE;
                    if (bus.sin && !perr_q) begin
                        d_d    = shift_q;
                        en_d   = 1'b1;
                        good_d = good_q + 8'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase

        if (time_out) begin
            state_d = IDLE;
            err_d   = 1'b1;
            gap_d   = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            gap_q   <= '0;
            d_q     <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            good_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            gap_q   <= gap_d;
            d_q     <= d_d;
            en_q    <= en_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            good_q  <= good_d;
        end
    end

    assign bus.D        = d_q;
    assign bus.en       = en_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
    assign bus.good_cnt = good_q;
endmodule

// File: tb/tb_nibble_deserializer.sv
// Bench for nibble_deserializer: vector table, corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_nibble_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   en_cnt = 0;
    logic en_seen, busy_seen, en_at_start;

    nibble_deserializer_if #(.WIDTH(4)) bus();

    nibble_deserializer #(
        .WIDTH(4), .PARITY_EN(1'b1), .ODD_PARITY(1'b0), .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.en === 1'b1) en_cnt = en_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] data;
        bit         pflip;
        bit         stop;
        int         gap;
        logic [3:0] exp_d;
        int         exp_en;
        bit         exp_err;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tv[7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            bus.sin_valid = 1'b0;
            bus.sin       = 1'($urandom);
        end
        @(negedge clk);
        en_seen       = bus.en;
        busy_seen     = bus.busy;
        bus.sin_valid = 1'b1;
        bus.sin       = b;
    endtask

    task automatic send_frame(input logic [3:0] data, input bit pflip,
                              input bit stop, input int gap);
        send_bit(1'b0, gap);
        en_at_start = en_seen;
        for (int i = 0; i < 4; i++) send_bit(data[i], gap);
        send_bit((^data) ^ pflip, gap);
        send_bit(stop, gap);
    endtask

    task automatic finish_frame();
        @(negedge clk);
        bus.sin_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.sin_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_outs(input string tag, input int base,
                              input int exp_en, input logic [3:0] exp_d,
                              input bit exp_err, input logic [7:0] exp_cnt);
        check({tag, "_en_pulses"}, en_cnt - base, exp_en);
        check({tag, "_D"}, bus.D, exp_d);
        check({tag, "_err"}, bus.err, exp_err);
        check({tag, "_good_cnt"}, bus.good_cnt, exp_cnt);
        check({tag, "_busy_idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        int         base;
        int         hits;
        logic [3:0] m_d;
        logic [7:0] m_cnt;
        bit         m_err;
        logic [3:0] data;

        bus.sin       = 1'b1;
        bus.sin_valid = 1'b0;

        tv[0] = '{4'b1101, 1'b0, 1'b1, 0, 4'b1101, 1, 1'b0, 8'd1};
        tv[1] = '{4'b1101, 1'b0, 1'b1, 3, 4'b1101, 1, 1'b0, 8'd2};
        tv[2] = '{4'b1101, 1'b1, 1'b1, 0, 4'b1101, 0, 1'b1, 8'd2};
        tv[3] = '{4'b1101, 1'b0, 1'b0, 1, 4'b1101, 0, 1'b1, 8'd2};
        tv[4] = '{4'b0100, 1'b0, 1'b1, 1, 4'b0100, 1, 1'b0, 8'd3};
        tv[5] = '{4'b1111, 1'b0, 1'b1, 2, 4'b1111, 1, 1'b0, 8'd4};
        tv[6] = '{4'b0000, 1'b0, 1'b1, 0, 4'b0000, 1, 1'b0, 8'd5};

        do_reset();
        check_outs("reset", en_cnt, 0, 4'h0, 1'b0, 8'd0);
        check("reset_en", bus.en, 1'b0);

        for (int i = 0; i < 7; i++) begin
            base = en_cnt;
            send_frame(tv[i].data, tv[i].pflip, tv[i].stop, tv[i].gap);
            check("vec_busy_in_frame", busy_seen, 1'b1);
            finish_frame();
            check_outs($sformatf("vec%0d", i), base, tv[i].exp_en,
                       tv[i].exp_d, tv[i].exp_err, tv[i].exp_cnt);
        end

        // bad stop, then the next start bit must clear err
        base = en_cnt;
        send_frame(4'b1010, 1'b0, 1'b0, 0);
        finish_frame();
        check_outs("badstop", base, 0, 4'b0000, 1'b1, 8'd5);
        send_bit(1'b0, 0);
        @(negedge clk);
        bus.sin_valid = 1'b0;
        check("start_clears_err", bus.err, 1'b0);
        check("start_sets_busy", bus.busy, 1'b1);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        finish_frame();
        check_outs("after_err", base, 1, 4'b1101, 1'b0, 8'd6);

        // timeout after start + 2 data bits
        base = en_cnt;
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            bus.sin_valid = 1'b0;
            if (i == 8) check("to_busy_before", bus.busy, 1'b1);
        end
        @(negedge clk);
        check_outs("timeout", base, 0, 4'b1101, 1'b1, 8'd6);
        send_frame(4'b0100, 1'b0, 1'b1, 0);
        finish_frame();
        check_outs("after_to", base, 1, 4'b0100, 1'b0, 8'd7);

        // reset mid-frame, with a valid bit present during reset
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.sin = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.sin_valid = 1'b0;
        check_outs("rst_mid", en_cnt, 0, 4'h0, 1'b0, 8'd0);
        check("rst_mid_en", bus.en, 1'b0);
        base = en_cnt;
        send_frame(4'b1111, 1'b0, 1'b1, 0);
        finish_frame();
        check_outs("after_rst", base, 1, 4'b1111, 1'b0, 8'd1);

        // randomized frames against a frame-level model
        m_d   = 4'b1111;
        m_cnt = 8'd1;
        m_err = 1'b0;
        for (int n = 0; n < 40; n++) begin
            int  gap;
            int  kind;
            bit  pflip;
            bit  stop;
            base = en_cnt;
            gap  = $urandom_range(0, 3);
            kind = $urandom_range(0, 9);
            data = 4'($urandom);
            if ($urandom_range(0, 3) == 0) send_bit(1'b1, gap);
            if (kind == 0) begin
                int k;
                k = $urandom_range(0, 3);
                send_bit(1'b0, gap);
                for (int i = 0; i < k; i++) send_bit(data[i], gap);
                repeat (9) begin
                    @(negedge clk);
                    bus.sin_valid = 1'b0;
                end
                m_err = 1'b1;
                check_outs("rnd_to", base, 0, m_d, m_err, m_cnt);
            end else begin
                pflip = (kind == 1);
                stop  = (kind != 2);
                send_frame(data, pflip, stop, gap);
                finish_frame();
                if (!pflip && stop) begin
                    m_d   = data;
                    m_cnt = m_cnt + 8'd1;
                    m_err = 1'b0;
                    check_outs("rnd_good", base, 1, m_d, m_err, m_cnt);
                end else begin
                    m_err = 1'b1;
                    check_outs("rnd_bad", base, 0, m_d, m_err, m_cnt);
                end
            end
        end

        // 256 back-to-back frames, each start issued while en is high
        do_reset();
        base = en_cnt;
        hits = 0;
        data = 4'h0;
        for (int n = 0; n < 256; n++) begin
            data = 4'($urandom);
            send_frame(data, 1'b0, 1'b1, 0);
            if (n > 0 && en_at_start === 1'b1) hits++;
        end
        finish_frame();
        check("b2b_start_on_en", hits, 255);
        check_outs("b2b", base, 256, data, 1'b0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
